// File: rtl/aabb_pkg.sv
// aabb_pkg: shared widths and fixed-point helpers
// for the slab and triangle intersectors.
package aabb_pkg;

  localparam int AABB_W     = 32;
  localparam int AABB_FRAC  = 16;
  localparam int AABB_TAG_W = 8;
  localparam int MAXW       = 32;
  localparam int PW         = 2*MAXW+1;

  localparam logic signed [PW-1:0] P_ONE = PW'(1);

  // floor shift of a full product, then clamp to a w-bit signed range
  function automatic logic signed [MAXW-1:0] sat_shift(
    input logic signed [PW-1:0] p,
    input int                   w,
    input int                   frac
  );
    logic signed [PW-1:0] s;
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    s  = p >>> frac;
    hi = (P_ONE <<< (w-1)) - P_ONE;
    lo = -(P_ONE <<< (w-1));
    if (s > hi)      return hi[MAXW-1:0];
    else if (s < lo) return lo[MAXW-1:0];
    else             return s[MAXW-1:0];
  endfunction

  function automatic logic signed [MAXW-1:0] smax(
    input logic signed [MAXW-1:0] a,
    input logic signed [MAXW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [MAXW-1:0] smin(
    input logic signed [MAXW-1:0] a,
    input logic signed [MAXW-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/aabb_slab_axis.sv
// aabb_slab_axis: one axis of the slab test,
// plane select, subtract, multiply/shift/saturate.
module aabb_slab_axis
  import aabb_pkg::*;
#(
  parameter int W    = AABB_W,
  parameter int FRAC = AABB_FRAC
) (
  input  logic                clk,
  input  logic                i_en,
  input  logic signed [W-1:0] i_bmin,
  input  logic signed [W-1:0] i_bmax,
  input  logic signed [W-1:0] i_org,
  input  logic signed [W-1:0] i_inv,
  input  logic                i_neg,
  output logic signed [W-1:0] o_tnear,
  output logic signed [W-1:0] o_tfar
);

  logic signed [W-1:0]    r_near;
  logic signed [W-1:0]    r_far;
  logic signed [W-1:0]    r_org;
  logic signed [W-1:0]    r_inv0;
  logic signed [W:0]      r_dn;
  logic signed [W:0]      r_df;
  logic signed [W-1:0]    r_inv1;
  logic signed [W:0]      w_dn;
  logic signed [W:0]      w_df;
  logic signed [2*W:0]    w_pn;
  logic signed [2*W:0]    w_pf;
  logic signed [MAXW-1:0] w_tn;
  logic signed [MAXW-1:0] w_tf;

  // one extra bit keeps the difference exact
  assign w_dn = (W+1)'(r_near) - (W+1)'(r_org);
  assign w_df = (W+1)'(r_far) - (W+1)'(r_org);

  assign w_pn = (2*W+1)'(r_dn) * (2*W+1)'(r_inv1);
  assign w_pf = (2*W+1)'(r_df) * (2*W+1)'(r_inv1);

  assign w_tn = sat_shift(PW'(w_pn), W, FRAC);
  assign w_tf = sat_shift(PW'(w_pf), W, FRAC);

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_near  <= i_neg ? i_bmax : i_bmin;
      r_far   <= i_neg ? i_bmin : i_bmax;
      r_org   <= i_org;
      r_inv0  <= i_inv;
      r_dn    <= w_dn;
      r_df    <= w_df;
      r_inv1  <= r_inv0;
      o_tnear <= w_tn[W-1:0];
      o_tfar  <= w_tf[W-1:0];
    end
  end

endmodule

// File: rtl/aabb_slab_pipe.sv
// aabb_slab_pipe: 4-stage ray/box slab intersector
// with valid/ready flow control and full-pipe stall.
module aabb_slab_pipe
  import aabb_pkg::*;
#(
  parameter int W     = AABB_W,
  parameter int FRAC  = AABB_FRAC,
  parameter int TAG_W = AABB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [W-1:0]     in_min_t,
  input  logic [W-1:0]     in_max_t,
  input  logic [3*W-1:0]   in_bmin,
  input  logic [3*W-1:0]   in_bmax,
  input  logic [3*W-1:0]   in_org,
  input  logic [3*W-1:0]   in_inv_dir,
  input  logic [2:0]       in_dir_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [W-1:0]     out_tmin,
  output logic [W-1:0]     out_tmax,
  output logic             out_hit
);

  logic                   w_stall;
  logic                   w_en;
  logic                   w_acc;
  logic [2:0]             r_v;
  logic [TAG_W-1:0]       r_tag  [3];
  logic signed [W-1:0]    r_mint [3];
  logic signed [W-1:0]    r_maxt [3];
  logic signed [W-1:0]    w_tn   [3];
  logic signed [W-1:0]    w_tf   [3];
  logic signed [MAXW-1:0] w_tmin;
  logic signed [MAXW-1:0] w_tmax;

  assign w_stall  = out_valid && !out_ready;
  assign w_en     = !w_stall;
  assign in_ready = w_en;
  assign w_acc    = in_valid && in_ready;

  for (genvar g = 0; g < 3; g++) begin : g_axis
    aabb_slab_axis #(
      .W    (W),
      .FRAC (FRAC)
    ) u_axis (
      .clk     (clk),
      .i_en    (w_en),
      .i_bmin  (in_bmin[g*W +: W]),
      .i_bmax  (in_bmax[g*W +: W]),
      .i_org   (in_org[g*W +: W]),
      .i_inv   (in_inv_dir[g*W +: W]),
      .i_neg   (in_dir_neg[g]),
      .o_tnear (w_tn[g]),
      .o_tfar  (w_tf[g])
    );
  end

  // each bound folds only from its own interval end
  assign w_tmin = smax(smax(MAXW'(r_mint[2]), MAXW'(w_tn[0])),
                       smax(MAXW'(w_tn[1]), MAXW'(w_tn[2])));
  assign w_tmax = smin(smin(MAXW'(r_maxt[2]), MAXW'(w_tf[0])),
                       smin(MAXW'(w_tf[1]), MAXW'(w_tf[2])));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v       <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_tmin  <= '0;
      out_tmax  <= '0;
      out_hit   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_tag[i]  <= '0;
        r_mint[i] <= '0;
        r_maxt[i] <= '0;
      end
    end else if (w_en) begin
      r_v       <= {r_v[1:0], w_acc};
      r_tag[0]  <= in_tag;
      r_mint[0] <= in_min_t;
      r_maxt[0] <= in_max_t;
      for (int i = 1; i < 3; i++) begin
        r_tag[i]  <= r_tag[i-1];
        r_mint[i] <= r_mint[i-1];
        r_maxt[i] <= r_maxt[i-1];
      end
      out_valid <= r_v[2];
      if (r_v[2]) begin
        out_tag  <= r_tag[2];
        out_tmin <= w_tmin[W-1:0];
        out_tmax <= w_tmax[W-1:0];
        out_hit  <= (w_tmin <= w_tmax);
      end
    end
  end

endmodule
